// File: rtl/guvm_wb_responder.sv
// Wishbone memory-side responder for the Amber 128-bit bus: reads are served from a
// bench-fed instruction FIFO, writes are captured into a store FIFO for checking.
module guvm_wb_responder #(
  parameter int          INS_DEPTH = 8,
  parameter int          ST_DEPTH  = 4,
  parameter int          ACK_LAT   = 1,
  parameter logic [31:0] FILL_WORD = 32'hF0801003
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_ins_valid,
  input  logic [31:0]  i_ins_data,
  output logic         o_ins_ready,
  output logic         o_st_valid,
  output logic [31:0]  o_st_adr,
  output logic [31:0]  o_st_dat,
  input  logic         i_st_ready,
  input  logic [31:0]  i_wb_adr,
  input  logic [15:0]  i_wb_sel,
  input  logic         i_wb_we,
  input  logic [127:0] i_wb_dat,
  input  logic         i_wb_cyc,
  input  logic         i_wb_stb,
  output logic [127:0] o_wb_dat,
  output logic         o_wb_ack,
  output logic         o_wb_err
);

  localparam int         IAW      = $clog2(INS_DEPTH);
  localparam int         SAW      = $clog2(ST_DEPTH);
  localparam logic [2:0] LAT_INIT = (ACK_LAT > 0) ? 3'(ACK_LAT - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        latch_en;
  logic [31:0] adr_q;
  logic        we_q;
  logic [15:0] sel_q;
  logic [31:0] wdat_q;

  logic [31:0]    ins_mem_q [INS_DEPTH];
  logic [IAW-1:0] ins_wr_q, ins_rd_q;
  logic [IAW:0]   ins_cnt_q;
  logic           ins_full, ins_empty, ins_push, ins_pop;

  logic [63:0]    st_mem_q [ST_DEPTH];
  logic [SAW-1:0] st_wr_q, st_rd_q;
  logic [SAW:0]   st_cnt_q;
  logic           st_full, st_empty, st_push, st_pop;
  logic [63:0]    st_head;

  logic err_w, res_ok, req_ok;

  assign ins_full  = (ins_cnt_q == (IAW+1)'(INS_DEPTH));
  assign ins_empty = (ins_cnt_q == '0);
  assign st_full   = (st_cnt_q == (SAW+1)'(ST_DEPTH));
  assign st_empty  = (st_cnt_q == '0);

  assign err_w  = we_q && (sel_q == '0);
  assign res_ok = we_q ? (err_w || !st_full) : !ins_empty;
  assign req_ok = i_wb_we ? ((i_wb_sel == '0) || !st_full) : !ins_empty;

  assign ins_push = i_ins_valid && !ins_full;
  assign ins_pop  = (state_q == S_RESP) && !we_q && !ins_empty;
  assign st_push  = (state_q == S_RESP) && we_q && !err_w && !st_full;
  assign st_pop   = !st_empty && i_st_ready;

  // NOTE: storage arrays are not reset; only pointers and counts are, and the
  // store-head outputs are masked to zero while that queue is empty.
  always_ff @(posedge i_clk) begin
    if (ins_push) ins_mem_q[ins_wr_q] <= i_ins_data;
    if (st_push)  st_mem_q[st_wr_q]   <= {adr_q, wdat_q};
  end

  // NOTE: every clocked block uses non-blocking assignments so all flops sample
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ins_wr_q  <= '0;
      ins_rd_q  <= '0;
      ins_cnt_q <= '0;
      st_wr_q   <= '0;
      st_rd_q   <= '0;
      st_cnt_q  <= '0;
    end else begin
      if (ins_push) ins_wr_q <= ins_wr_q + 1'b1;
      if (ins_pop)  ins_rd_q <= ins_rd_q + 1'b1;
      case ({ins_push, ins_pop})
        2'b10:   ins_cnt_q <= ins_cnt_q + 1'b1;
        2'b01:   ins_cnt_q <= ins_cnt_q - 1'b1;
        default: ;
      endcase
      if (st_push) st_wr_q <= st_wr_q + 1'b1;
      if (st_pop)  st_rd_q <= st_rd_q + 1'b1;
      case ({st_push, st_pop})
        2'b10:   st_cnt_q <= st_cnt_q + 1'b1;
        2'b01:   st_cnt_q <= st_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        adr_q  <= i_wb_adr;
        we_q   <= i_wb_we;
        sel_q  <= i_wb_sel;
        wdat_q <= i_wb_dat[{i_wb_adr[3:2], 5'd0} +: 32];
      end
    end
  end

  // NOTE: defaults come first so no path through the case leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          latch_en = 1'b1;
          // Zero latency still honours the resource check; a stall parks in WAIT.
          if ((ACK_LAT == 0) && req_ok) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc)          state_d = S_IDLE;
        else if (cnt_q != '0)   cnt_d   = cnt_q - 1'b1;
        else if (res_ok)        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_wb_dat = {4{FILL_WORD}};
    if ((state_q == S_RESP) && !we_q) o_wb_dat[{adr_q[3:2], 5'd0} +: 32] = ins_mem_q[ins_rd_q];
  end

  assign st_head     = st_mem_q[st_rd_q];
  assign o_wb_ack    = (state_q == S_RESP) && !err_w;
  assign o_wb_err    = (state_q == S_RESP) && err_w;
  assign o_ins_ready = !ins_full;
  assign o_st_valid  = !st_empty;
  assign o_st_adr    = st_empty ? 32'd0 : st_head[63:32];
  assign o_st_dat    = st_empty ? 32'd0 : st_head[31:0];

endmodule

// File: tb/tb_guvm_wb_responder.sv
// Directed plus randomized bench for guvm_wb_responder against a queue-based
// model of the instruction and store queues.
module tb_guvm_wb_responder;

  localparam int          LAT   = 1;
  localparam int          DEPTH = 8;
  localparam logic [31:0] FILL  = 32'hF0801003;

  logic         i_clk, i_rst_n;
  logic         i_ins_valid;
  logic [31:0]  i_ins_data;
  logic         o_ins_ready, o_st_valid;
  logic [31:0]  o_st_adr, o_st_dat;
  logic         i_st_ready;
  logic [31:0]  i_wb_adr;
  logic [15:0]  i_wb_sel;
  logic         i_wb_we;
  logic [127:0] i_wb_dat;
  logic         i_wb_cyc, i_wb_stb;
  logic [127:0] o_wb_dat;
  logic         o_wb_ack, o_wb_err;

  int tests = 0;
  int fails = 0;
  logic [31:0] ins_q[$];
  logic [63:0] st_q[$];

  guvm_wb_responder #(
    .INS_DEPTH(DEPTH), .ST_DEPTH(4), .ACK_LAT(LAT), .FILL_WORD(FILL)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ins_valid(i_ins_valid), .i_ins_data(i_ins_data), .o_ins_ready(o_ins_ready),
    .o_st_valid(o_st_valid), .o_st_adr(o_st_adr), .o_st_dat(o_st_dat), .i_st_ready(i_st_ready),
    .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_rdat(input int lane, input logic [31:0] word);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = (k == lane) ? word : FILL;
    return r;
  endfunction

  task automatic push_ins(input logic [31:0] w);
    check("ins_ready", o_ins_ready, ins_q.size() < DEPTH);
    i_ins_valid = 1'b1;
    i_ins_data  = w;
    tick;
    i_ins_valid = 1'b0;
    if (ins_q.size() < DEPTH) ins_q.push_back(w);
  endtask

  task automatic pop_store(input string tag);
    check({tag, "_valid"}, o_st_valid, 1);
    check({tag, "_adr"}, o_st_adr, st_q[0][63:32]);
    check({tag, "_dat"}, o_st_dat, st_q[0][31:0]);
    i_st_ready = 1'b1;
    tick;
    i_st_ready = 1'b0;
    void'(st_q.pop_front());
  endtask

  // One unstalled transfer; optionally offers an instruction push during RESP.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [15:0] sel, input logic [127:0] wdat,
                      input logic offer, input logic [31:0] offer_w,
                      output logic [127:0] rdat);
    int cycles, lane;
    logic ack, err, exp_err, accept;
    lane    = int'(adr[3:2]);
    exp_err = we && (sel == 16'h0);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr;  i_wb_sel = sel;  i_wb_dat = wdat;
    cycles = 0;
    do begin
      tick;
      cycles++;
    end while (!(o_wb_ack || o_wb_err) && cycles < 40);
    ack = o_wb_ack; err = o_wb_err; rdat = o_wb_dat;
    check({tag, "_lat"}, cycles, LAT + 1);
    check({tag, "_ack"}, ack, !exp_err);
    check({tag, "_err"}, err, exp_err);
    if (!we) check({tag, "_rdat"}, rdat, exp_rdat(lane, ins_q[0]));
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    if (offer) begin
      i_ins_valid = 1'b1;
      i_ins_data  = offer_w;
    end
    accept = ins_q.size() < DEPTH;
    tick;
    i_ins_valid = 1'b0;
    if (!we) void'(ins_q.pop_front());
    else if (!exp_err) st_q.push_back({adr, wdat[lane*32 +: 32]});
    if (offer && accept) ins_q.push_back(offer_w);
  endtask

  initial begin
    logic [127:0] wd, rd;
    logic         seen;
    logic [15:0]  sel;
    i_rst_n = 1'b0; i_ins_valid = 1'b0; i_ins_data = '0; i_st_ready = 1'b0;
    i_wb_adr = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_dat = '0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    repeat (2) tick;
    check("rst_ack", o_wb_ack, 0);
    check("rst_err", o_wb_err, 0);
    check("rst_ins_ready", o_ins_ready, 1);
    check("rst_st_valid", o_st_valid, 0);
    check("rst_st_adr", o_st_adr, 0);
    check("rst_st_dat", o_st_dat, 0);
    check("rst_wb_dat", o_wb_dat, {4{FILL}});
    i_rst_n = 1'b1;
    tick;

    // Basic read, lane 0
    push_ins(32'hE0812003);
    xfer("t1", 1'b0, 32'h0, 16'hFFFF, '0, 1'b0, '0, rd);
    check("t1_const", rd, 128'hF0801003_F0801003_F0801003_E0812003);

    // Stalled read on an empty queue, released by a late push
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h8; i_wb_sel = 16'hFFFF;
    seen = 1'b0;
    repeat (6) begin
      tick;
      if (o_wb_ack || o_wb_err) seen = 1'b1;
    end
    check("t2_stall", seen, 0);
    i_ins_valid = 1'b1; i_ins_data = 32'hE3A01005;
    tick;
    i_ins_valid = 1'b0;
    check("t2_push_edge_ack", o_wb_ack, 0);
    tick;
    check("t2_ack", o_wb_ack, 1);
    check("t2_dat", o_wb_dat, 128'hF0801003_E3A01005_F0801003_F0801003);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick;

    // Write capture into the store queue
    wd = {$urandom, $urandom, 32'h0000002A, $urandom};
    xfer("t3", 1'b1, 32'h104, 16'h00F0, wd, 1'b0, '0, rd);
    check("t3_st_adr", o_st_adr, 32'h104);
    check("t3_st_dat", o_st_dat, 32'h2A);
    pop_store("t3_pop");
    check("t3_st_empty", o_st_valid, 0);

    // Error write and aborts
    xfer("t5_err", 1'b1, 32'h40, 16'h0, {4{$urandom}}, 1'b0, '0, rd);
    check("t5_err_nostore", o_st_valid, 0);
    push_ins(32'h11112222);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'hC;
    tick;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick;
      if (o_wb_ack || o_wb_err) seen = 1'b1;
    end
    check("t5_abort_rd_noack", seen, 0);
    xfer("t5_after_abort", 1'b0, 32'hC, 16'hFFFF, '0, 1'b0, '0, rd);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = 32'h50; i_wb_sel = 16'h000F;
    tick;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick;
      if (o_wb_ack || o_wb_err) seen = 1'b1;
    end
    check("t5_abort_wr_noack", seen, 0);
    check("t5_abort_wr_nostore", o_st_valid, 0);

    // Fill, refused push during a RESP pop, drain across pointer wrap
    for (int i = 0; i < DEPTH; i++) push_ins($urandom);
    check("t4_full", o_ins_ready, 0);
    push_ins(32'hDEADBEEF);
    xfer("t4_pop_full", 1'b0, 32'h4, 16'hFFFF, '0, 1'b1, 32'hBADC0DE0, rd);
    check("t4_ready_after", o_ins_ready, 1);
    for (int i = 0; i < DEPTH - 1; i++) xfer("t4_drain", 1'b0, $urandom, 16'hFFFF, '0, 1'b0, '0, rd);

    // Randomized mix of pushes, reads and writes
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: push_ins($urandom);
        1: begin
          if (ins_q.size() > 0) xfer("rnd_rd", 1'b0, $urandom, 16'hFFFF, '0, 1'b0, '0, rd);
          else push_ins($urandom);
        end
        default: begin
          sel = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) | 16'h1);
          xfer("rnd_wr", 1'b1, $urandom, sel, {$urandom, $urandom, $urandom, $urandom},
               1'b0, '0, rd);
          if (sel != 16'h0) pop_store("rnd_st");
          else check("rnd_err_nostore", o_st_valid, 0);
        end
      endcase
    end

    // Reset during WAIT with three queued instructions and a pending store
    while (ins_q.size() > 0) xfer("t6_drain", 1'b0, $urandom, 16'hFFFF, '0, 1'b0, '0, rd);
    for (int i = 0; i < 3; i++) push_ins($urandom);
    xfer("t6_wr", 1'b1, 32'h20, 16'h000F, {4{32'h5A5A0001}}, 1'b0, '0, rd);
    check("t6_st_pending", o_st_valid, 1);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h0;
    tick;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_ack", o_wb_ack, 0);
    check("t6_rst_err", o_wb_err, 0);
    check("t6_rst_wb_dat", o_wb_dat, {4{FILL}});
    check("t6_rst_ins_ready", o_ins_ready, 1);
    check("t6_rst_st_valid", o_st_valid, 0);
    check("t6_rst_st_adr", o_st_adr, 0);
    check("t6_rst_st_dat", o_st_dat, 0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick;
    i_rst_n = 1'b1;
    ins_q.delete();
    st_q.delete();
    tick;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h4;
    seen = 1'b0;
    repeat (6) begin
      tick;
      if (o_wb_ack || o_wb_err) seen = 1'b1;
    end
    check("t6_queue_empty", seen, 0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    repeat (2) tick;
    push_ins(32'hCAFEF00D);
    xfer("t6_resume", 1'b0, 32'hC, 16'hFFFF, '0, 1'b0, '0, rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/guvm_wb_responder.md
# guvm_wb_responder

Wishbone slave that sits directly on the Amber core's 128-bit bus, on the memory side of the GUVM verification interface. It replaces direct driving of bus read data from the testbench. The bench pushes 32-bit instruction words into a queue, and the responder returns them to the core's fetch/read cycles with a programmable acknowledge latency. Core write cycles are captured into a store queue that the bench drains to check results.

## Interface
Parameters:
- INS_DEPTH, 8, instruction queue entries (power of 2, ≥2)
- ST_DEPTH, 4, store capture queue entries (power of 2, ≥2)
- ACK_LAT, 1, wait cycles between request sample and ack (0–7)
- FILL_WORD, 32'hF0801003, NOP word placed in non-addressed read lanes

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_ins_valid  in  1  bench offers an instruction word
- i_ins_data  in  32  instruction word
- o_ins_ready  out  1  instruction queue not full
- o_st_valid  out  1  store queue head valid
- o_st_adr  out  32  captured write address
- o_st_dat  out  32  captured write data (addressed lane)
- i_st_ready  in  1  bench consumes store head
- i_wb_adr  in  32  core bus address
- i_wb_sel  in  16  core byte selects
- i_wb_we  in  1  core write enable
- i_wb_dat  in  128  core write data
- i_wb_cyc  in  1  core cycle
- i_wb_stb  in  1  core strobe
- o_wb_dat  out  128  read data to core
- o_wb_ack  out  1  transfer acknowledge
- o_wb_err  out  1  transfer error

## Operation
- Lane = i_wb_adr[3:2]. Lane k occupies bits [32k+31:32k].
- Instruction queue: synchronous FIFO. A push occurs when i_ins_valid & o_ins_ready. o_ins_ready = !full, computed from the registered count, so a pop in the same cycle does not enable a push into a full queue.
- Store queue: FIFO of {adr, dat}. A pop occurs when o_st_valid & i_st_ready. o_st_valid = !empty.
- FSM states:
  - IDLE
    - On i_wb_cyc & i_wb_stb, latch adr, we, sel and the write-lane data, then go to WAIT.
    - If ACK_LAT=0, go straight to RESP.
  - WAIT
    - A counter loads ACK_LAT-1 and decrements.
    - At 0, go to RESP when the resource is ready: a read needs the instruction queue non-empty; a write needs the store queue not full. Otherwise stay in WAIT (stall).
  - RESP
    - o_wb_ack=1 for exactly one cycle, then go to IDLE.
    - Read: o_wb_dat = FILL_WORD in every lane except the latched lane, which carries the instruction-queue head. The head pops at the end of RESP.
    - Write: push {adr, lane data} into the store queue at the end of RESP.
- Error path:
  - A write with latched i_wb_sel == 0 goes to RESP with o_wb_err=1 and o_wb_ack=0, and pushes nothing.
  - A read never errors.
- Abort: if i_wb_cyc falls while in WAIT, return to IDLE with no pop and no push.
- Outside RESP, o_wb_dat = {4{FILL_WORD}}.

## Timing
- Reset (async assert, sync release): FSM=IDLE, both queues empty, o_ins_ready=1, o_st_valid=0, o_st_adr=0, o_st_dat=0, o_wb_ack=0, o_wb_err=0, o_wb_dat={4{FILL_WORD}}.
- Reset mid-transfer: the request is dropped and both queue contents are lost.
- Request sampled in IDLE at edge T: o_wb_ack is high in cycle T+1+ACK_LAT when unstalled. Each stall cycle adds one cycle.
- There is one dead IDLE cycle after every RESP. Back-to-back throughput is one transfer per ACK_LAT+2 cycles.
- A pushed instruction is visible to a stalled read on the cycle after the push.
- The store head is visible on o_st_* the cycle after RESP.
- Simultaneous push and pop on either queue leaves the count unchanged.
- Pointers wrap modulo depth.
- The full/empty flags use a (log2 depth)+1-bit count.

## Test plan
- Reset, push 32'hE0812003, core read at adr 0x0, ACK_LAT=1 → ack in cycle T+2; o_wb_dat = {F0801003, F0801003, F0801003, E0812003}; queue empty afterwards.
- Read at adr 0x8 with empty queue; push 32'hE3A01005 five cycles later → ack exactly one cycle after the push becomes visible; lane 2 = E3A01005, other lanes FILL_WORD.
- Write adr 0x104, sel 16'h00F0, lane 1 data 32'h0000002A → o_st_valid; o_st_adr=0x104, o_st_dat=0x2A; pops on i_st_ready.
- Fill the instruction queue with 8 words → o_ins_ready=0. Push attempted during a RESP pop is refused; count stays 8→7; the remaining 7 words are read back in order, including across pointer wrap.
- Write with sel=0 → o_wb_err for one cycle, o_wb_ack=0, store queue unchanged. Drop i_wb_cyc mid-WAIT → no ack and queue unchanged.
- Assert i_rst_n=0 during WAIT with 3 queued instructions → outputs return to reset values immediately and queue reads empty after release.
